// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard transmitter: the FSM state type,
// the frame length and the helpers that build an 11-bit device-to-host frame.
// No ports (package).
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BIT_HI,
    BIT_LO,
    GAP
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;

  // Odd parity: the parity bit makes the total count of ones (data + parity)
  // odd, so it is 1 exactly when the data byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Frame laid out LSB-first as it leaves the wire: bit 0 is the start bit,
  // bits 8:1 the data, bit 9 parity and bit 10 the stop bit.
  function automatic logic [PS2_FRAME_BITS-1:0] make_frame(input logic [7:0] b);
    return {1'b1, odd_parity(b), b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_kbd_tx_if
// Byte-queue side of the PS/2 transmitter (the SPI/OSD writer talks here).
//   data_i      scancode byte to queue
//   wr_i        write strobe, one byte per cycle
//   full_o      FIFO full
//   overflow_o  one-cycle pulse when a write was dropped
//   busy_o      transmitter active or bytes pending
// master = byte producer, slave = ps2_kbd_tx.
// ---------------------------------------------------------------------------
interface ps2_kbd_tx_if;

  logic [7:0] data_i;
  logic       wr_i;
  logic       full_o;
  logic       overflow_o;
  logic       busy_o;

  modport master (
    output data_i,
    output wr_i,
    input  full_o,
    input  overflow_o,
    input  busy_o
  );

  modport slave (
    input  data_i,
    input  wr_i,
    output full_o,
    output overflow_o,
    output busy_o
  );

endinterface

// File: rtl/ps2_tx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_tx_fifo
// Small synchronous FIFO holding scancodes waiting to be serialised.
//   clk_sys, res_n  clock / async active-low reset
//   wr, din         write request and data (ignored while full)
//   rd              pop request (ignored while empty)
//   dout            head of queue (combinational read)
//   count           number of stored bytes, 0..2**FIFO_AW
//   full, empty     derived from count
// ---------------------------------------------------------------------------
module ps2_tx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk_sys,
  input  logic               res_n,
  input  logic               wr,
  input  logic [7:0]         din,
  input  logic               rd,
  output logic [7:0]         dout,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 2**FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wrPtr_q;
  logic [FIFO_AW-1:0] rdPtr_q;
  logic [FIFO_AW:0]   count_q;
  logic               doWr;
  logic               doRd;

  // Full is judged on the registered count, so a write arriving in the same
  // cycle as a pop from a full FIFO is still refused.
  assign full  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign doWr  = wr && !full;
  assign doRd  = rd && !empty;
  assign dout  = mem[rdPtr_q];
  assign count = count_q;

  // Pointer and occupancy bookkeeping. Pointers are exactly FIFO_AW bits wide
  // so they wrap modulo the depth on their own; a simultaneous push and pop
  // leaves the count untouched.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWr) wrPtr_q <= wrPtr_q + FIFO_AW'(1);
      if (doRd) rdPtr_q <= rdPtr_q + FIFO_AW'(1);
      case ({doWr, doRd})
        2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because only counted entries are
  // ever read.
  always_ff @(posedge clk_sys) begin
    if (doWr) mem[wrPtr_q] <= din;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_tx
// PS/2 device-to-host transmitter. Bytes written through the interface are
// queued and sent as 11-bit keyboard frames on a self-generated PS/2 clock.
//   clk_sys       system clock (rising edge)
//   res_n         asynchronous active-low reset
//   bus           ps2_kbd_tx_if.slave: data_i, wr_i, full_o, overflow_o, busy_o
//   ps2_kbd_clk   PS/2 clock, idle high
//   ps2_kbd_data  PS/2 data, idle high
// Parameters: CLK_DIV (cycles per half-period, >= 2), GAP_CYCLES (idle
// cycles after each stop bit, >= 1), FIFO_AW (FIFO depth = 2**FIFO_AW).
// ---------------------------------------------------------------------------
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 750,
  parameter int GAP_CYCLES = 3000,
  parameter int FIFO_AW    = 4
) (
  input  logic         clk_sys,
  input  logic         res_n,
  ps2_kbd_tx_if.slave  bus,
  output logic         ps2_kbd_clk,
  output logic         ps2_kbd_data
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e                state_q, state_d;
  logic [CNT_W-1:0]          divCnt_q, divCnt_d;
  logic [3:0]                bitCnt_q, bitCnt_d;
  logic [PS2_FRAME_BITS-1:0] shReg_q, shReg_d;

  logic clk_q, clk_d;
  logic data_q, data_d;
  logic busy_q, busy_d;
  logic overflow_q;

  logic               fifoRd;
  logic [7:0]         fifoDout;
  logic [FIFO_AW:0]   fifoCount;
  logic               fifoFull;
  logic               fifoEmpty;

  ps2_tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_sys (clk_sys),
    .res_n   (res_n),
    .wr      (bus.wr_i),
    .din     (bus.data_i),
    .rd      (fifoRd),
    .dout    (fifoDout),
    .count   (fifoCount),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  // FSM state, shared divider/gap counter, bit counter and shift register.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state_q  <= IDLE;
      divCnt_q <= '0;
      bitCnt_q <= '0;
      shReg_q  <= '0;
    end else begin
      state_q  <= state_d;
      divCnt_q <= divCnt_d;
      bitCnt_q <= bitCnt_d;
      shReg_q  <= shReg_d;
    end
  end

  // Next-state logic. One counter times both the half-periods and the
  // inter-frame gap, since they never overlap. The shift happens only when
  // leaving BIT_LO, so shReg_q[0] is steady for a whole clock period and the
  // data line can only change on entry to BIT_HI.
  always_comb begin
    state_d  = state_q;
    divCnt_d = divCnt_q;
    bitCnt_d = bitCnt_q;
    shReg_d  = shReg_q;
    fifoRd   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifoEmpty) state_d = LOAD;
      end

      LOAD: begin
        fifoRd   = 1'b1;
        shReg_d  = make_frame(fifoDout);
        bitCnt_d = '0;
        divCnt_d = '0;
        state_d  = BIT_HI;
      end

      BIT_HI: begin
        if (divCnt_q == DIV_LAST) begin
          divCnt_d = '0;
          state_d  = BIT_LO;
        end else begin
          divCnt_d = divCnt_q + CNT_W'(1);
        end
      end

      BIT_LO: begin
        if (divCnt_q == DIV_LAST) begin
          divCnt_d = '0;
          shReg_d  = {1'b0, shReg_q[PS2_FRAME_BITS-1:1]};
          bitCnt_d = bitCnt_q + 4'd1;
          state_d  = (bitCnt_q == BIT_LAST) ? GAP : BIT_HI;
        end else begin
          divCnt_d = divCnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (divCnt_q == GAP_LAST) begin
          divCnt_d = '0;
          state_d  = IDLE;
        end else begin
          divCnt_d = divCnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output values are decoded from the current state and registered, so the
  // pins lag the state by one cycle and never glitch.
  always_comb begin
    clk_d  = (state_q != BIT_LO);
    data_d = 1'b1;
    if (state_q == BIT_HI || state_q == BIT_LO) data_d = shReg_q[0];
    busy_d = (state_q != IDLE) || (fifoCount != '0);
  end

  // Registered outputs; the async reset parks both PS/2 lines high at once,
  // even mid-frame.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      clk_q      <= 1'b1;
      data_q     <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      clk_q      <= clk_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      overflow_q <= bus.wr_i && fifoFull;
    end
  end

  assign ps2_kbd_clk    = clk_q;
  assign ps2_kbd_data   = data_q;
  assign bus.busy_o     = busy_q;
  assign bus.overflow_o = overflow_q;
  assign bus.full_o     = fifoFull;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_tx
// Directed bench for ps2_kbd_tx with a timeline model of the expected pin
// activity, a falling-edge frame receiver and literal frame expectations.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_tx;

  localparam int D     = 4;
  localparam int G     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;

  logic clk_sys;
  logic res_n;
  logic ps2_kbd_clk;
  logic ps2_kbd_data;

  ps2_kbd_tx_if bus();

  ps2_kbd_tx #(
    .CLK_DIV    (D),
    .GAP_CYCLES (G),
    .FIFO_AW    (AW)
  ) dut (
    .clk_sys      (clk_sys),
    .res_n        (res_n),
    .bus          (bus),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  logic [10:0] rxFrames[$];
  int          rxBitCnt = 0;

  logic        expClk  = 1'b1;
  logic        expData = 1'b1;
  logic        expFull = 1'b0;
  logic        expOvf  = 1'b0;
  logic        expBusy = 1'b0;

  // Free-running clock.
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Edge counter: after posedge n the value is n.
  always @(posedge clk_sys) cycle <= cycle + 1;

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic logic [10:0] frameOf(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Timeline model. Each frame is anchored at the edge L where its byte is
  // popped; k cycles after L+1 the pins show bit k/(2D), clock high for the
  // first D cycles of each bit. The transmitter is busy from L-1 to
  // L+22D+G-1 and looks for the next byte one edge after that window.
  initial begin : model
    int          mEdge;
    int          mCount;
    int          curL;
    int          prevCount;
    int          k;
    bit          prevBusyWin;
    bit          accept;
    logic [7:0]  modelQ[$];
    logic [10:0] curFrame;
    mEdge    = 0;
    mCount   = 0;
    curL     = -100000;
    curFrame = '1;
    forever begin
      @(posedge clk_sys);
      if (!res_n) begin
        mEdge = 0;
        mCount = 0;
        modelQ.delete();
        curL = -100000;
        expClk = 1'b1; expData = 1'b1; expFull = 1'b0; expOvf = 1'b0; expBusy = 1'b0;
      end else begin
        mEdge++;
        prevCount   = mCount;
        prevBusyWin = (mEdge - 1 >= curL - 1) && (mEdge - 1 <= curL + 22*D + G - 1);
        accept      = bus.wr_i && (prevCount < DEPTH);
        expOvf      = bus.wr_i && (prevCount == DEPTH);
        if (mEdge == curL && modelQ.size() > 0) curFrame = frameOf(modelQ.pop_front());
        if (accept) modelQ.push_back(bus.data_i);
        mCount = modelQ.size();
        if (!prevBusyWin && prevCount != 0) curL = mEdge + 1;
        expBusy = prevBusyWin || (prevCount != 0);
        expFull = (mCount == DEPTH);
        k = mEdge - curL - 1;
        if (k >= 0 && k < 22*D) begin
          expClk  = (k % (2*D)) < D;
          expData = curFrame[k / (2*D)];
        end else begin
          expClk  = 1'b1;
          expData = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin : compare
    forever begin
      @(posedge clk_sys);
      #1;
      if (res_n) begin
        checkOutput("ps2_clk",  32'(ps2_kbd_clk),    32'(expClk));
        checkOutput("ps2_data", 32'(ps2_kbd_data),   32'(expData));
        checkOutput("full",     32'(bus.full_o),     32'(expFull));
        checkOutput("overflow", 32'(bus.overflow_o), 32'(expOvf));
        checkOutput("busy",     32'(bus.busy_o),     32'(expBusy));
      end
    end
  end

  // Host-side receiver: samples data on each PS/2 clock fall, bit i of the
  // stored word is the i-th sample.
  initial begin : receiver
    logic [10:0] sh;
    sh = '0;
    forever begin
      @(negedge ps2_kbd_clk or negedge res_n);
      if (!res_n) begin
        rxBitCnt = 0;
      end else begin
        sh[rxBitCnt] = ps2_kbd_data;
        rxBitCnt++;
        if (rxBitCnt == 11) begin
          rxFrames.push_back(sh);
          rxBitCnt = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk_sys);
    bus.data_i = b;
    bus.wr_i   = 1'b1;
  endtask

  task automatic releaseBus();
    @(negedge clk_sys);
    bus.wr_i = 1'b0;
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    repeat (3) @(negedge clk_sys);
    while (bus.busy_o !== 1'b0 && n < bound) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("idle_timeout", 32'(n < bound), 32'd1);
  endtask

  logic [7:0] vec4[18];
  logic [7:0] vec6[17];

  initial begin : main
    int base;
    int wEdge;
    int n;
    bus.data_i = 8'h00;
    bus.wr_i   = 1'b0;
    res_n      = 1'b0;
    for (int i = 0; i < 18; i++) vec4[i] = 8'(i * 29 + 5);
    for (int i = 0; i < 17; i++) vec6[i] = 8'(i * 13 + 100);

    repeat (4) @(negedge clk_sys);
    #1;
    checkOutput("reset_clk",  32'(ps2_kbd_clk),    32'd1);
    checkOutput("reset_data", 32'(ps2_kbd_data),   32'd1);
    checkOutput("reset_busy", 32'(bus.busy_o),     32'd0);
    checkOutput("reset_full", 32'(bus.full_o),     32'd0);
    checkOutput("reset_ovf",  32'(bus.overflow_o), 32'd0);
    @(negedge clk_sys);
    res_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // 1: single 0x1C frame, start-bit latency and first fall
    $display("[TB] test 1: single byte 0x1C");
    base = rxFrames.size();
    applyStimulus(8'h1C);
    wEdge = cycle + 1;
    releaseBus();
    checkOutput("t1_data_e0", 32'(ps2_kbd_data), 32'd1);
    @(negedge clk_sys);
    checkOutput("t1_data_e1", 32'(ps2_kbd_data), 32'd1);
    @(negedge clk_sys);
    checkOutput("t1_data_e2", 32'(ps2_kbd_data), 32'd1);
    @(negedge clk_sys);
    checkOutput("t1_edge",    32'(cycle - wEdge), 32'd3);
    checkOutput("t1_start",   32'(ps2_kbd_data), 32'd0);
    repeat (D - 1) @(negedge clk_sys);
    checkOutput("t1_clk_hi",  32'(ps2_kbd_clk), 32'd1);
    @(negedge clk_sys);
    checkOutput("t1_clk_fall", 32'(ps2_kbd_clk), 32'd0);
    waitIdle(400);
    checkOutput("t1_nframes", 32'(rxFrames.size() - base), 32'd1);
    if (rxFrames.size() > base) checkOutput("t1_frame", 32'(rxFrames[base]), 32'h438);
    checkOutput("t1_partial", 32'(rxBitCnt), 32'd0);

    // 2: 0xF0 then 0x1C back to back
    $display("[TB] test 2: 0xF0, 0x1C back to back");
    base = rxFrames.size();
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    releaseBus();
    waitIdle(600);
    checkOutput("t2_nframes", 32'(rxFrames.size() - base), 32'd2);
    if (rxFrames.size() > base + 1) begin
      checkOutput("t2_frame0", 32'(rxFrames[base]),     32'h7E0);
      checkOutput("t2_frame1", 32'(rxFrames[base + 1]), 32'h438);
    end
    checkOutput("t2_busy", 32'(bus.busy_o), 32'd0);

    // 3: parity for all-zero and all-one bytes
    $display("[TB] test 3: 0x00, 0xFF parity");
    base = rxFrames.size();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    releaseBus();
    waitIdle(600);
    checkOutput("t3_nframes", 32'(rxFrames.size() - base), 32'd2);
    if (rxFrames.size() > base + 1) begin
      checkOutput("t3_frame0", 32'(rxFrames[base]),     32'h600);
      checkOutput("t3_frame1", 32'(rxFrames[base + 1]), 32'h7FE);
    end

    // 4: 18-byte burst, 17 accepted, 18th dropped
    $display("[TB] test 4: 18-byte burst");
    base = rxFrames.size();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_sys);
      if (i == 16) checkOutput("t4_full_before", 32'(bus.full_o), 32'd0);
      if (i == 17) checkOutput("t4_full_after",  32'(bus.full_o), 32'd1);
      bus.data_i = vec4[i];
      bus.wr_i   = 1'b1;
    end
    releaseBus();
    checkOutput("t4_ovf_pulse", 32'(bus.overflow_o), 32'd1);
    @(negedge clk_sys);
    checkOutput("t4_ovf_end",   32'(bus.overflow_o), 32'd0);
    waitIdle(3000);
    checkOutput("t4_nframes", 32'(rxFrames.size() - base), 32'd17);
    if (rxFrames.size() >= base + 17)
      for (int i = 0; i < 17; i++)
        checkOutput("t4_byte", 32'(rxFrames[base + i][8:1]), 32'(vec4[i]));

    // 6: write dropped in the same cycle as the pop from a full FIFO
    $display("[TB] test 6: write during pop at full");
    base = rxFrames.size();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vec6[i]);
      if (i == 0) wEdge = cycle + 1;
    end
    releaseBus();
    checkOutput("t6_full", 32'(bus.full_o), 32'd1);
    n = 0;
    while (cycle < wEdge + 99 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    bus.data_i = 8'hEE;
    bus.wr_i   = 1'b1;
    @(negedge clk_sys);
    bus.wr_i = 1'b0;
    checkOutput("t6_ovf_pulse", 32'(bus.overflow_o), 32'd1);
    checkOutput("t6_full_drop", 32'(bus.full_o),     32'd0);
    @(negedge clk_sys);
    checkOutput("t6_ovf_end",   32'(bus.overflow_o), 32'd0);
    waitIdle(3000);
    checkOutput("t6_nframes", 32'(rxFrames.size() - base), 32'd17);
    if (rxFrames.size() >= base + 17)
      for (int i = 0; i < 17; i++)
        checkOutput("t6_byte", 32'(rxFrames[base + i][8:1]), 32'(vec6[i]));

    // 5: reset during BIT_LO of bit 5
    $display("[TB] test 5: reset mid-frame");
    base = rxFrames.size();
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    releaseBus();
    n = 0;
    while (rxBitCnt != 6 && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("t5_reach_bit5", 32'(n < 400), 32'd1);
    checkOutput("t5_clk_low",    32'(ps2_kbd_clk), 32'd0);
    #2;
    res_n = 1'b0;
    #1;
    checkOutput("t5_rst_clk",  32'(ps2_kbd_clk),  32'd1);
    checkOutput("t5_rst_data", 32'(ps2_kbd_data), 32'd1);
    checkOutput("t5_rst_busy", 32'(bus.busy_o),   32'd0);
    checkOutput("t5_rst_full", 32'(bus.full_o),   32'd0);
    repeat (3) @(negedge clk_sys);
    res_n = 1'b1;
    repeat (200) @(negedge clk_sys);
    checkOutput("t5_no_frame", 32'(rxFrames.size() - base), 32'd0);
    checkOutput("t5_no_bits",  32'(rxBitCnt), 32'd0);
    checkOutput("t5_idle",     32'(bus.busy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
